// File: rtl/sync_pkg.sv
// Shared types for the multi-channel rendezvous (multi_syncer / sync_slot).
package sync_pkg;

   typedef enum logic {
      KEEP_FIRST,
      KEEP_LATEST
   } overrun_policy_t;

   typedef enum logic {
      COLLECT,
      HOLD
   } sync_state_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/sync_slot.sv
// One rendezvous channel: sample register, received flag and overrun policy.
// slot_next/received_now expose this cycle's capture so a release can include it.
module sync_slot
   import sync_pkg::*;
#(
   parameter int              DATA_WIDTH     = 32,
   parameter overrun_policy_t OVERRUN_POLICY = KEEP_LATEST
) (
   input  logic                  clk_pixel_in,
   input  logic                  rst_in,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] slot_next,
   output logic                  flag,
   output logic                  received_now,
   output logic                  overrun
);

   logic [DATA_WIDTH-1:0] slot_q;
   logic                  write_en;

   assign overrun      = valid & flag;
   assign write_en     = valid & (~flag | (OVERRUN_POLICY == KEEP_LATEST));
   assign slot_next    = write_en ? data : slot_q;
   assign received_now = flag | valid;

   // NOTE: the sample register is reset too; a timeout release publishes it, so it must read 0 after reset.
   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         slot_q <= '0;
         flag   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         slot_q <= slot_next;
         flag   <= clear ? 1'b0 : received_now;
      end
   end

endmodule

// File: rtl/multi_syncer.sv
// Collects one sample per channel and releases them as an aligned, held bundle,
// with optional timeout release (stale mask) and saturating diagnostic counters.
module multi_syncer
   import sync_pkg::*;
#(
   parameter int              NUM_CH         = 2,
   parameter int              DATA_WIDTH     = 32,
   parameter int              TIMEOUT_CYCLES = 0,
   parameter overrun_policy_t OVERRUN_POLICY = KEEP_LATEST
) (
   input  logic                         clk_pixel_in,
   input  logic                         rst_in,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_in,
   input  logic [NUM_CH-1:0]            ch_valid_in,
   output logic [NUM_CH*DATA_WIDTH-1:0] bundle_out,
   output logic                         bundle_valid_out,
   input  logic                         bundle_ready_in,
   output logic [NUM_CH-1:0]            stale_mask_out,
   output logic [CNT_W-1:0]             overrun_count_out,
   output logic [CNT_W-1:0]             timeout_count_out
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [NUM_CH*DATA_WIDTH-1:0] slot_next;
   logic [NUM_CH-1:0]            flag;
   logic [NUM_CH-1:0]            received_now;
   logic [NUM_CH-1:0]            overrun;
   logic                         clear;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      sync_slot #(
         .DATA_WIDTH     (DATA_WIDTH),
         .OVERRUN_POLICY (OVERRUN_POLICY)
      ) u_slot (
         .clk_pixel_in (clk_pixel_in),
         .rst_in       (rst_in),
         .valid        (ch_valid_in[i]),
         .data         (ch_data_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .clear        (clear),
         .slot_next    (slot_next[i*DATA_WIDTH +: DATA_WIDTH]),
         .flag         (flag[i]),
         .received_now (received_now[i]),
         .overrun      (overrun[i])
      );
   end

   sync_state_t   state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic          complete, expire, do_release, timed_out;

   assign timer_inc        = timer_q + TW'(1);
   assign complete         = &received_now;
   assign expire           = (TIMEOUT_CYCLES > 0) && (|flag) && (timer_inc == TW'(TIMEOUT_CYCLES));
   assign bundle_valid_out = (state_q == HOLD);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      clear      = 1'b0;
      do_release = 1'b0;
      timed_out  = 1'b0;
      case (state_q)
         COLLECT: begin
            if (complete || expire) begin
               do_release = 1'b1;
               clear      = 1'b1;
               timed_out  = !complete;
               timer_d    = '0;
               state_d    = HOLD;
            end else if ((TIMEOUT_CYCLES > 0) && (|flag)) begin
               timer_d = timer_inc;
            end
         end
         HOLD: begin
            // A complete follow-on bundle is released from COLLECT on the next cycle.
            if (bundle_ready_in) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= COLLECT;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         bundle_out        <= '0;
         stale_mask_out    <= '0;
         overrun_count_out <= '0;
         timeout_count_out <= '0;
      end else begin
         if (do_release) begin
            bundle_out     <= slot_next;
            stale_mask_out <= ~received_now;
         end
         // One count per cycle with any overrun, however many channels collided.
         if ((|overrun) && (overrun_count_out != '1))
            overrun_count_out <= overrun_count_out + CNT_W'(1);
         if (timed_out && (timeout_count_out != '1))
            timeout_count_out <= timeout_count_out + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multi_syncer.sv
// Bench for multi_syncer: instance a (KEEP_LATEST, timeout 10) and b (KEEP_FIRST, no timeout) share stimulus.
module tb_multi_syncer;
   import sync_pkg::*;

   localparam int DW = 8;
   localparam int T_A = 10;

   logic        clk_pixel_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [15:0] ch_data_in = '0;
   logic [1:0]  ch_valid_in = '0;
   logic        bundle_ready_in = 1'b0;

   logic [15:0] a_bundle, b_bundle;
   logic        a_valid, b_valid;
   logic [1:0]  a_stale, b_stale;
   logic [7:0]  a_ovr, b_ovr, a_to, b_to;

   int checks = 0;
   int errors = 0;

   always #5 clk_pixel_in = ~clk_pixel_in;

   multi_syncer #(.NUM_CH(2), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T_A), .OVERRUN_POLICY(KEEP_LATEST)) dut_a (
      .clk_pixel_in      (clk_pixel_in),
      .rst_in            (rst_in),
      .ch_data_in        (ch_data_in),
      .ch_valid_in       (ch_valid_in),
      .bundle_out        (a_bundle),
      .bundle_valid_out  (a_valid),
      .bundle_ready_in   (bundle_ready_in),
      .stale_mask_out    (a_stale),
      .overrun_count_out (a_ovr),
      .timeout_count_out (a_to)
   );

   multi_syncer #(.NUM_CH(2), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0), .OVERRUN_POLICY(KEEP_FIRST)) dut_b (
      .clk_pixel_in      (clk_pixel_in),
      .rst_in            (rst_in),
      .ch_data_in        (ch_data_in),
      .ch_valid_in       (ch_valid_in),
      .bundle_out        (b_bundle),
      .bundle_valid_out  (b_valid),
      .bundle_ready_in   (bundle_ready_in),
      .stale_mask_out    (b_stale),
      .overrun_count_out (b_ovr),
      .timeout_count_out (b_to)
   );

   // Reference model: per instance, pending samples, held bundle and an age in COLLECT cycles.
   int m_slot   [2][2];
   bit m_have   [2][2];
   int m_bundle [2][2];
   int m_stale  [2];
   bit m_hold   [2];
   int m_age    [2];
   int m_ovr    [2];
   int m_to     [2];

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 2; c++) begin
            m_slot[m][c]   = 0;
            m_have[m][c]   = 1'b0;
            m_bundle[m][c] = 0;
         end
         m_stale[m] = 0;
         m_hold[m]  = 1'b0;
         m_age[m]   = 0;
         m_ovr[m]   = 0;
         m_to[m]    = 0;
      end
   endfunction

   function automatic void model_step(int m, bit latest, int tmo);
      bit collided = 1'b0;
      bit was_pending, complete, expired;
      int sample;
      was_pending = m_have[m][0] || m_have[m][1];
      for (int c = 0; c < 2; c++) begin
         if (ch_valid_in[c]) begin
            sample = int'(ch_data_in[c*DW +: DW]);
            if (m_have[m][c]) begin
               collided = 1'b1;
               if (latest) m_slot[m][c] = sample;
            end else begin
               m_slot[m][c] = sample;
               m_have[m][c] = 1'b1;
            end
         end
      end
      if (collided && m_ovr[m] < 255) m_ovr[m]++;
      if (m_hold[m]) begin
         if (bundle_ready_in) m_hold[m] = 1'b0;
      end else begin
         if (was_pending) m_age[m]++;
         complete = m_have[m][0] && m_have[m][1];
         expired  = (tmo > 0) && was_pending && (m_age[m] == tmo);
         if (complete || expired) begin
            m_bundle[m][0] = m_slot[m][0];
            m_bundle[m][1] = m_slot[m][1];
            m_stale[m] = (m_have[m][0] ? 0 : 1) + (m_have[m][1] ? 0 : 2);
            if (!complete && m_to[m] < 255) m_to[m]++;
            m_have[m][0] = 1'b0;
            m_have[m][1] = 1'b0;
            m_age[m] = 0;
            m_hold[m] = 1'b1;
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      model_step(0, 1'b1, T_A);
      model_step(1, 1'b0, 0);
      @(posedge clk_pixel_in);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [15:0] d, input logic r);
      ch_valid_in     = v;
      ch_data_in      = d;
      bundle_ready_in = r;
   endtask

   task automatic do_reset();
      drive(2'b00, 16'h0, 1'b0);
      @(negedge clk_pixel_in);
      rst_in = 1'b1;
      model_reset();
      @(negedge clk_pixel_in);
      @(negedge clk_pixel_in);
      rst_in = 1'b0;
      @(posedge clk_pixel_in);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " a_outputs"}, {a_bundle, a_valid, a_stale, a_ovr, a_to}, 32'h0);
      check({tag, " b_outputs"}, {b_bundle, b_valid, b_stale, b_ovr, b_to}, 32'h0);
   endtask

   task automatic compare_model();
      check("rnd a_valid",  a_valid,  m_hold[0]);
      check("rnd a_bundle", a_bundle, 32'(m_bundle[0][1] * 256 + m_bundle[0][0]));
      check("rnd a_stale",  a_stale,  32'(m_stale[0]));
      check("rnd a_ovr",    a_ovr,    32'(m_ovr[0]));
      check("rnd a_to",     a_to,     32'(m_to[0]));
      check("rnd b_valid",  b_valid,  m_hold[1]);
      check("rnd b_bundle", b_bundle, 32'(m_bundle[1][1] * 256 + m_bundle[1][0]));
      check("rnd b_stale",  b_stale,  32'(m_stale[1]));
      check("rnd b_ovr",    b_ovr,    32'(m_ovr[1]));
      check("rnd b_to",     b_to,     32'(m_to[1]));
   endtask

   typedef struct packed {
      logic [1:0]  valid;
      logic [15:0] data;
      logic        ready;
      logic        exp_valid;
      logic [15:0] exp_bundle;
      logic [1:0]  exp_stale;
   } vec_t;

   vec_t vecs [10];

   initial begin
      // Basic rendezvous: ch0 at cycle 3, ch1 at cycle 7, bundle visible from cycle 8.
      vecs[0] = '{2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00};
      vecs[1] = '{2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00};
      vecs[2] = '{2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00};
      vecs[3] = '{2'b01, 16'h0011, 1'b0, 1'b0, 16'h0000, 2'b00};
      vecs[4] = '{2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00};
      vecs[5] = '{2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00};
      vecs[6] = '{2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00};
      vecs[7] = '{2'b10, 16'h2200, 1'b0, 1'b1, 16'h2211, 2'b00};
      vecs[8] = '{2'b00, 16'h0000, 1'b1, 1'b0, 16'h2211, 2'b00};
      vecs[9] = '{2'b00, 16'h0000, 1'b1, 1'b0, 16'h2211, 2'b00};

      model_reset();
      do_reset();
      check_zero("reset");

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].valid, vecs[i].data, vecs[i].ready);
         tick();
         check($sformatf("vec%0d a_valid", i),  a_valid,  vecs[i].exp_valid);
         check($sformatf("vec%0d a_bundle", i), a_bundle, vecs[i].exp_bundle);
         check($sformatf("vec%0d a_stale", i),  a_stale,  vecs[i].exp_stale);
         check($sformatf("vec%0d b_valid", i),  b_valid,  vecs[i].exp_valid);
         check($sformatf("vec%0d b_bundle", i), b_bundle, vecs[i].exp_bundle);
      end

      // Backpressure: bundle held while ch0 is buffered for the next one.
      drive(2'b11, 16'h0605, 1'b0); tick();
      check("bp first a_valid", a_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         if (i == 0) drive(2'b01, 16'h00AA, 1'b0);
         else        drive(2'b00, 16'h0000, 1'b0);
         tick();
         check("bp hold a_valid",  a_valid,  1'b1);
         check("bp hold a_bundle", a_bundle, 16'h0605);
         check("bp hold b_bundle", b_bundle, 16'h0605);
      end
      drive(2'b00, 16'h0000, 1'b1); tick();
      check("bp xfer a_valid", a_valid, 1'b0);
      drive(2'b10, 16'hBB00, 1'b0); tick();
      check("bp next a_valid",  a_valid,  1'b1);
      check("bp next a_bundle", a_bundle, 16'hBBAA);
      check("bp next b_bundle", b_bundle, 16'hBBAA);
      check("bp next a_stale",  a_stale,  2'b00);

      // Overrun policy.
      do_reset();
      drive(2'b01, 16'h0001, 1'b0); tick();
      drive(2'b01, 16'h0002, 1'b0); tick();
      drive(2'b10, 16'h0300, 1'b0); tick();
      check("ovr a_bundle", a_bundle, 16'h0302);
      check("ovr b_bundle", b_bundle, 16'h0301);
      check("ovr a_count",  a_ovr, 8'd1);
      check("ovr b_count",  b_ovr, 8'd1);

      // Timeout release with stale mask, then coincident completion.
      do_reset();
      drive(2'b11, 16'h4477, 1'b0); tick();
      drive(2'b00, 16'h0000, 1'b1); tick();
      drive(2'b10, 16'h3300, 1'b0); tick();
      drive(2'b00, 16'h0000, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      check("to early a_valid", a_valid, 1'b0);
      tick();
      check("to a_valid",  a_valid,  1'b1);
      check("to a_bundle", a_bundle, 16'h3377);
      check("to a_stale",  a_stale,  2'b01);
      check("to a_count",  a_to,     8'd1);
      check("to b_valid",  b_valid,  1'b0);
      drive(2'b00, 16'h0000, 1'b1); tick();
      drive(2'b10, 16'h5500, 1'b0); tick();
      drive(2'b00, 16'h0000, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      check("coin early a_valid", a_valid, 1'b0);
      drive(2'b01, 16'h0066, 1'b0); tick();
      check("coin a_valid",  a_valid,  1'b1);
      check("coin a_bundle", a_bundle, 16'h5566);
      check("coin a_stale",  a_stale,  2'b00);
      check("coin a_count",  a_to,     8'd1);
      check("coin b_bundle", b_bundle, 16'h3366);

      // Overrun counter saturation.
      do_reset();
      for (int i = 0; i < 301; i++) begin
         drive(2'b01, 16'($urandom_range(0, 255)), 1'b0);
         tick();
      end
      check("sat a_ovr", a_ovr, 8'd255);
      check("sat b_ovr", b_ovr, 8'd255);

      // Asynchronous reset in the middle of HOLD.
      do_reset();
      drive(2'b01, 16'h0001, 1'b0); tick();
      drive(2'b11, 16'h0302, 1'b0); tick();
      check("arst pre a_valid", a_valid, 1'b1);
      check("arst pre a_ovr",   a_ovr,   8'd1);
      drive(2'b00, 16'h0000, 1'b0);
      #2 rst_in = 1'b1;
      #1 check_zero("arst");
      model_reset();
      @(negedge clk_pixel_in);
      rst_in = 1'b0;
      @(posedge clk_pixel_in);
      #1;
      drive(2'b10, 16'h1200, 1'b0); tick();
      check("arst partial a_valid", a_valid, 1'b0);
      check("arst partial b_valid", b_valid, 1'b0);
      drive(2'b01, 16'h0034, 1'b0); tick();
      check("arst fresh a_valid",  a_valid,  1'b1);
      check("arst fresh a_bundle", a_bundle, 16'h1234);

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive(2'($urandom_range(0, 3) & $urandom_range(0, 3)),
               16'($urandom), ($urandom_range(0, 2) != 0));
         tick();
         compare_model();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
